// File: rtl/mc_seq_pkg.sv
// Shared constants for the multi-channel pulse sequencer: register map, MODE bits, FSM states, CMD codes.
// Also holds the byte-enable merge helper used by the register bank.
package mc_seq_pkg;

  localparam int NSTEP = 47;
  localparam int CW    = 24;
  localparam int PTR_W = $clog2(NSTEP);

  localparam logic [7:0]    NSTEP_MAX = 8'(NSTEP);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [31:0] ADDR_MODE  = 32'h0000_0200;
  localparam logic [31:0] ADDR_PORT  = 32'h0000_0204;
  localparam logic [31:0] ADDR_FB    = 32'h0000_0208;
  localparam logic [31:0] ADDR_REP   = 32'h0000_020C;
  localparam logic [31:0] ADDR_POL   = 32'h0000_0210;
  localparam logic [31:0] ADDR_DEF   = 32'h0000_0214;
  localparam logic [31:0] ADDR_STEP0 = 32'h0000_0218;
  localparam logic [31:0] ADDR_STEPN = 32'h0000_02D0;

  localparam int MODE_LVL  = 0;
  localparam int MODE_BCD  = 1;
  localparam int MODE_SOFT = 2;

  localparam logic [7:0] CMD_START = 8'd1;
  localparam logic [7:0] CMD_STOP  = 8'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/mc_trig_filter.sv
// Trigger qualifier: level goes high after i_width consecutive high cycles (min 1), drops the first low cycle.
// Soft mode ignores the pin and follows set/clear commands; o_rise pulses for one cycle on each rising level.
module mc_trig_filter
  import mc_seq_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tin,
  input  logic          i_soft,
  input  logic          i_set,
  input  logic          i_clr,
  input  logic [CW-1:0] i_width,
  output logic          o_lvl,
  output logic          o_rise
);
  logic [CW-1:0] r_cnt;
  logic          r_qual;
  logic          r_soft;
  logic          r_prev;
  logic [CW-1:0] w_thr;
  logic [CW:0]   w_cnt_inc;
  logic          w_lvl;

  assign w_thr     = (i_width == '0) ? CNT_ONE : i_width;
  assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  // The drop is combinational so the level falls in the same cycle the pin does.
  assign w_lvl     = i_soft ? r_soft : (r_qual & i_tin);
  assign o_lvl     = w_lvl;
  assign o_rise    = w_lvl & ~r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_qual <= 1'b0;
      r_soft <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_lvl;
      if (!i_tin) begin
        r_cnt  <= '0;
        r_qual <= 1'b0;
      end else begin
        if (r_cnt != '1) r_cnt <= w_cnt_inc[CW-1:0];
        if (w_cnt_inc >= {1'b0, w_thr}) r_qual <= 1'b1;
      end
      if (i_set)      r_soft <= 1'b1;
      else if (i_clr) r_soft <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_channel_pulse_seq.sv
// 32-channel trigger-driven output sequencer: register bank, step table, sequencer FSM, feedback timer.
// io_Out updates one cycle after trigger qualification; BUS_DATA_RD is live only with MC_READBACK_EN.
module multi_channel_pulse_seq
  import mc_seq_pkg::*;
(
  input  logic        io_clk,
  input  logic        io_rst,
  input  logic        io_rst_ram,
  input  logic [31:0] BUS_ADDR,
  input  logic [3:0]  BUS_BE,
  input  logic [31:0] BUS_DATA_WR,
  output logic [31:0] BUS_DATA_RD,
  input  logic        io_pulseIn,
  output logic        io_fbOut,
  output logic [31:0] io_Out
);
  logic [2:0]       r_mode;
  logic [CW-1:0]    r_trigw, r_outw, r_fbdly;
  logic [7:0]       r_nport;
  logic [15:0]      r_repeat, r_fbw;
  logic [1:0]       r_pol;
  logic [31:0]      r_def;
  logic [31:0]      r_step [NSTEP];

  seq_state_t       r_state, w_state_nxt;
  logic [31:0]      r_out, w_out_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [15:0]      r_rep, w_rep_nxt;
  logic [CW-1:0]    r_wcnt, w_wcnt_nxt;
  logic             w_fb_start;
  logic             r_fb_dly, r_fb_act;
  logic [CW-1:0]    r_fb_cnt;

  logic             w_rst;
  logic [31:0]      w_word, w_step_off, w_reg_sel, w_nm;
  logic             w_step_hit;
  logic [PTR_W-1:0] w_step_idx;
  logic             w_cmd_wr, w_cmd_set, w_cmd_clr;
  logic             w_lvl, w_rise;
  logic [7:0]       w_nport_eff;
  logic             w_pulse_mode, w_ptr_last;
  logic [CW-1:0]    w_outw_eff;
  logic [16:0]      w_rep_eff, w_rep_inc;
  logic             w_unused;

  assign w_rst      = io_rst | io_rst_ram;
  assign w_word     = {BUS_ADDR[31:2], 2'b00};
  assign w_step_off = w_word - ADDR_STEP0;
  assign w_step_hit = (w_word >= ADDR_STEP0) && (w_word <= ADDR_STEPN);
  assign w_step_idx = w_step_off[PTR_W+1:2];
  assign w_unused   = &{1'b0, BUS_ADDR[1:0], w_step_off[31:PTR_W+2], w_step_off[1:0]};

  // Addressed-register view: feeds both the byte-merge for writes and the readback port.
  always_comb begin
    w_reg_sel = '0;
    case (w_word)
      ADDR_MODE: w_reg_sel = {r_trigw, 5'b0, r_mode};
      ADDR_PORT: w_reg_sel = {r_outw, r_nport};
      ADDR_FB:   w_reg_sel = {8'h00, r_fbdly};
      ADDR_REP:  w_reg_sel = {r_fbw, r_repeat};
      ADDR_POL:  w_reg_sel = {30'b0, r_pol};
      ADDR_DEF:  w_reg_sel = r_def;
      default:   if (w_step_hit) w_reg_sel = r_step[w_step_idx];
    endcase
  end

  assign w_nm = be_merge(w_reg_sel, BUS_DATA_WR, BUS_BE);

  always_ff @(posedge io_clk) begin
    if (|BUS_BE) begin
      case (w_word)
        ADDR_MODE: begin r_trigw <= w_nm[31:8];  r_mode   <= w_nm[2:0];  end
        ADDR_PORT: begin r_outw  <= w_nm[31:8];  r_nport  <= w_nm[7:0];  end
        ADDR_FB:   r_fbdly <= w_nm[23:0];
        ADDR_REP:  begin r_fbw   <= w_nm[31:16]; r_repeat <= w_nm[15:0]; end
        ADDR_POL:  r_pol <= w_nm[1:0];
        ADDR_DEF:  r_def <= w_nm;
        default:   if (w_step_hit) r_step[w_step_idx] <= w_nm;
      endcase
    end
  end

`ifdef MC_READBACK_EN
  assign BUS_DATA_RD = w_reg_sel;
`else
  assign BUS_DATA_RD = '0;
`endif

  assign w_cmd_wr  = BUS_BE[3] && (w_word == ADDR_FB);
  assign w_cmd_set = w_cmd_wr && (BUS_DATA_WR[31:24] == CMD_START);
  assign w_cmd_clr = w_cmd_wr && (BUS_DATA_WR[31:24] == CMD_STOP);

  mc_trig_filter u_trig (
    .i_clk   (io_clk),
    .i_rst   (w_rst),
    .i_tin   (io_pulseIn ^ r_pol[0]),
    .i_soft  (r_mode[MODE_SOFT]),
    .i_set   (w_cmd_set),
    .i_clr   (w_cmd_clr),
    .i_width (r_trigw),
    .o_lvl   (w_lvl),
    .o_rise  (w_rise)
  );

  assign w_nport_eff  = (r_nport > NSTEP_MAX) ? NSTEP_MAX : r_nport;
  assign w_pulse_mode = (r_mode[MODE_BCD:MODE_LVL] == 2'b00);
  assign w_outw_eff   = (r_outw == '0) ? CNT_ONE : r_outw;
  assign w_rep_eff    = (r_repeat == '0) ? 17'd1 : {1'b0, r_repeat};
  assign w_rep_inc    = {1'b0, r_rep} + 17'd1;
  assign w_ptr_last   = ({{(8-PTR_W){1'b0}}, r_ptr} + 8'd1) >= w_nport_eff;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_ptr_nxt   = r_ptr;
    w_rep_nxt   = r_rep;
    w_wcnt_nxt  = r_wcnt;
    w_fb_start  = 1'b0;
    case (r_state)
      IDLE: begin
        w_out_nxt = r_def;
        if (w_rise && (w_nport_eff != 8'd0)) begin
          w_state_nxt = ACTIVE;
          w_out_nxt   = r_def ^ r_step[r_ptr];
          w_wcnt_nxt  = CNT_ONE;
          w_fb_start  = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_pulse_mode) begin
          if (r_wcnt >= w_outw_eff) begin
            w_state_nxt = DONE;
            w_out_nxt   = r_def;
          end else begin
            w_wcnt_nxt = r_wcnt + CNT_ONE;
          end
        end else if (!w_lvl) begin
          w_state_nxt = DONE;
          w_out_nxt   = r_def;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_out_nxt   = r_def;
        if (w_rep_inc >= w_rep_eff) begin
          w_rep_nxt = '0;
          w_ptr_nxt = w_ptr_last ? '0 : r_ptr + 1'b1;
        end else begin
          w_rep_nxt = w_rep_inc[15:0];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge io_clk) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_out   <= r_def;
      r_ptr   <= '0;
      r_rep   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rep   <= w_rep_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Feedback timer: delay phase then active phase; a new start simply reloads it.
  always_ff @(posedge io_clk) begin
    if (w_rst) begin
      r_fb_dly <= 1'b0;
      r_fb_act <= 1'b0;
      r_fb_cnt <= '0;
    end else if (w_fb_start) begin
      r_fb_cnt <= CNT_ONE;
      r_fb_dly <= (r_fbw != '0) && (r_fbdly != '0);
      r_fb_act <= (r_fbw != '0) && (r_fbdly == '0);
    end else if (r_fb_dly) begin
      if (r_fb_cnt >= r_fbdly) begin
        r_fb_dly <= 1'b0;
        r_fb_act <= 1'b1;
        r_fb_cnt <= CNT_ONE;
      end else begin
        r_fb_cnt <= r_fb_cnt + CNT_ONE;
      end
    end else if (r_fb_act) begin
      if (r_fb_cnt >= {{(CW-16){1'b0}}, r_fbw}) r_fb_act <= 1'b0;
      else                                     r_fb_cnt <= r_fb_cnt + CNT_ONE;
    end
  end

  assign io_fbOut = r_fb_act ? r_pol[1] : ~r_pol[1];
  assign io_Out   = r_out;

endmodule

// File: tb/tb_multi_channel_pulse_seq.sv
// Directed bench for multi_channel_pulse_seq with scaled-down widths (TRIGW=4, OUTW=6, FBDLY=3, FBW=2).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_multi_channel_pulse_seq;
  logic        io_clk = 1'b0;
  logic        io_rst, io_rst_ram, io_pulseIn;
  logic [31:0] BUS_ADDR, BUS_DATA_WR;
  logic [3:0]  BUS_BE;
  logic [31:0] BUS_DATA_RD, io_Out;
  logic        io_fbOut;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DEF = 32'hA500_0000;
  localparam logic [31:0] S0  = 32'h0000_0010;
  localparam logic [31:0] S1  = 32'h0000_0020;
  localparam logic [31:0] S2  = 32'h0000_0040;

  multi_channel_pulse_seq dut (
    .io_clk      (io_clk),
    .io_rst      (io_rst),
    .io_rst_ram  (io_rst_ram),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_BE      (BUS_BE),
    .BUS_DATA_WR (BUS_DATA_WR),
    .BUS_DATA_RD (BUS_DATA_RD),
    .io_pulseIn  (io_pulseIn),
    .io_fbOut    (io_fbOut),
    .io_Out      (io_Out)
  );

  always #5 io_clk = ~io_clk;

  task automatic step(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    BUS_ADDR    = a;
    BUS_DATA_WR = d;
    BUS_BE      = be;
    step(1);
    BUS_BE      = 4'h0;
  endtask

  task automatic restart();
    io_rst_ram = 1'b1;
    step(1);
    io_rst_ram = 1'b0;
    step(1);
  endtask

  // Pulse mode trigger: output appears TRIGW+1 edges after the pin rises and lasts OUTW cycles.
  task automatic pulse_trig(input string tag, input logic [31:0] stp);
    io_pulseIn = 1'b1;
    step(4);
    chk({tag, "_pre"}, io_Out, DEF);
    step(1);
    chk({tag, "_on"}, io_Out, DEF ^ stp);
    step(5);
    chk({tag, "_hold"}, io_Out, DEF ^ stp);
    step(1);
    chk({tag, "_off"}, io_Out, DEF);
    io_pulseIn = 1'b0;
    step(3);
  endtask

  initial begin
    io_rst = 1'b1; io_rst_ram = 1'b0; io_pulseIn = 1'b0;
    BUS_ADDR = '0; BUS_DATA_WR = '0; BUS_BE = 4'h0;
    step(1);
    bus_wr(32'h200, 32'h0000_0400, 4'hF);
    bus_wr(32'h204, 32'h0000_0603, 4'hF);
    bus_wr(32'h208, 32'h0000_0003, 4'hF);
    bus_wr(32'h20C, 32'h0002_0000, 4'hF);
    bus_wr(32'h210, 32'h0000_0002, 4'hF);
    bus_wr(32'h214, DEF, 4'hF);
    bus_wr(32'h218, S0, 4'hF);
    bus_wr(32'h21C, S1, 4'hF);
    bus_wr(32'h220, S2, 4'hF);
    step(2);
    chk("rst_out", io_Out, DEF);
    chk("rst_fb", {31'b0, io_fbOut}, 32'h0);
    BUS_ADDR = 32'h214;
    #1;
`ifdef MC_READBACK_EN
    chk("rd_def", BUS_DATA_RD, DEF);
`else
    chk("rd_tied", BUS_DATA_RD, 32'h0);
`endif
    io_rst = 1'b0;
    step(3);
    chk("idle_out", io_Out, DEF);

    // First pulse trigger with feedback timing
    io_pulseIn = 1'b1;
    step(4);
    chk("t0_pre", io_Out, DEF);
    step(1);
    chk("t0_on", io_Out, DEF ^ S0);
    chk("fb_a0", {31'b0, io_fbOut}, 32'h0);
    step(2);
    chk("fb_a2", {31'b0, io_fbOut}, 32'h0);
    step(1);
    chk("fb_a3", {31'b0, io_fbOut}, 32'h1);
    step(1);
    chk("fb_a4", {31'b0, io_fbOut}, 32'h1);
    step(1);
    chk("fb_a5", {31'b0, io_fbOut}, 32'h0);
    chk("t0_hold", io_Out, DEF ^ S0);
    step(1);
    chk("t0_off", io_Out, DEF);
    io_pulseIn = 1'b0;
    step(3);

    // Pin high for fewer than TRIGW cycles must not qualify
    io_pulseIn = 1'b1;
    step(3);
    io_pulseIn = 1'b0;
    step(3);
    chk("short_pin", io_Out, DEF);

    pulse_trig("t1", S1);
    pulse_trig("t2", S2);
    pulse_trig("wrap", S0);

    // REPEAT=2, feedback disabled
    bus_wr(32'h20C, 32'h0000_0002, 4'hF);
    restart();
    pulse_trig("rp0a", S0);
    pulse_trig("rp0b", S0);
    pulse_trig("rp1", S1);
    chk("fb_off", {31'b0, io_fbOut}, 32'h0);
    bus_wr(32'h20C, 32'h0000_0001, 4'hF);

    // Level mode
    bus_wr(32'h200, 32'h0000_0401, 4'hF);
    restart();
    io_pulseIn = 1'b1;
    step(4);
    chk("lv_pre", io_Out, DEF);
    step(1);
    chk("lv_on", io_Out, DEF ^ S0);
    step(10);
    chk("lv_hold", io_Out, DEF ^ S0);
    io_pulseIn = 1'b0;
    step(1);
    chk("lv_off", io_Out, DEF);
    step(3);
    io_pulseIn = 1'b1;
    step(5);
    chk("lv2_on", io_Out, DEF ^ S1);
    io_pulseIn = 1'b0;
    step(1);
    chk("lv2_off", io_Out, DEF);
    step(3);

    // Soft level mode: pin ignored, CMD byte drives the trigger
    bus_wr(32'h200, 32'h0000_0405, 4'hF);
    restart();
    io_pulseIn = 1'b1;
    step(8);
    chk("sf_pin_ign", io_Out, DEF);
    bus_wr(32'h208, 32'h0100_0000, 4'h8);
    step(1);
    chk("sf_start", io_Out, DEF ^ S0);
    bus_wr(32'h208, 32'h0200_0000, 4'h8);
    step(1);
    chk("sf_stop", io_Out, DEF);
    step(2);
    bus_wr(32'h208, 32'h0100_0000, 4'h8);
    step(1);
    chk("sf_next", io_Out, DEF ^ S1);
    bus_wr(32'h208, 32'h0100_0000, 4'h8);
    step(3);
    chk("sf_restart_ign", io_Out, DEF ^ S1);
    chk("sf_fb", {31'b0, io_fbOut}, 32'h0);
    bus_wr(32'h208, 32'h0200_0000, 4'h8);
    io_pulseIn = 1'b0;
    step(3);

    // Restart mid-ACTIVE
    bus_wr(32'h200, 32'h0000_0400, 4'hF);
    restart();
    pulse_trig("rs0", S0);
    io_pulseIn = 1'b1;
    step(5);
    chk("rs_act", io_Out, DEF ^ S1);
    step(2);
    io_rst_ram = 1'b1;
    io_pulseIn = 1'b0;
    step(1);
    chk("rs_abort", io_Out, DEF);
    io_rst_ram = 1'b0;
    step(2);
    pulse_trig("rs_again", S0);

    // NPORT=0 keeps DEFAULT
    bus_wr(32'h204, 32'h0000_0600, 4'hF);
    io_pulseIn = 1'b1;
    step(8);
    chk("np0", io_Out, DEF);
    io_pulseIn = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
